// File: rtl/stepper_move_scheduler.sv
// stepper_move_scheduler
//
// This block sequences relative stepper-motor moves for the application
// processor. It accepts one move command at a time over a valid/ready
// handshake. A command carries a signed step count, the step mode and the
// inter-step delay. The block then:
//   - tracks the absolute position in half-step units,
//   - drives the 4-phase coil pattern,
//   - paces the steps with an internal delay counter,
//   - signals completion with a one-cycle done pulse.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset (highest priority)
//   cmd_valid   move command present
//   cmd_ready   high only in IDLE; a command is taken when cmd_valid is high
//   cmd_steps   signed step count (positive = forward, negative = reverse)
//   cmd_half    1 = half step (+/-1 per step), 0 = full step (+/-2 per step)
//   cmd_delay   inter-step delay, in units of TICK_DIV clock cycles
//   abort       end the current move early (ignored in IDLE and STEP)
//   home        in IDLE with no command pending, zero the position
//   position    absolute half-step position, modulo 2^POS_W
//   coil        phase pattern {A,B,C,D}; registered from position
//   step_pulse  high for the single STEP cycle
//   busy        high in every state other than IDLE
//   done        one-cycle completion pulse
//   aborted     qualifies done; 1 if the move ended through abort

module stepper_move_scheduler #(
  parameter int unsigned POS_W    = 8,
  parameter int unsigned COUNT_W  = 8,
  parameter int unsigned DLY_W    = 8,
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COUNT_W-1:0] cmd_steps,
  input  logic               cmd_half,
  input  logic [DLY_W-1:0]   cmd_delay,
  input  logic               abort,
  input  logic               home,
  output logic [POS_W-1:0]   position,
  output logic [3:0]         coil,
  output logic               step_pulse,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  // The counter must hold (2^DLY_W) * TICK_DIV - 1.
  localparam int unsigned CNT_W = DLY_W + $clog2(TICK_DIV + 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    STEP,
    WAIT,
    DONE
  } state_t;

  state_t             state;

  // Copy of the command that was latched at acceptance.
  logic               dir_neg;
  logic [COUNT_W-1:0] remaining;
  logic [POS_W-1:0]   inc;
  logic [DLY_W-1:0]   dly;

  logic [CNT_W-1:0]   dly_cnt;

  logic [COUNT_W-1:0] cmd_mag;
  logic [CNT_W-1:0]   wait_load;
  logic [POS_W-1:0]   pos_next;
  logic [3:0]         coil_next;

  // Magnitude of the step count as an unsigned value.
  // The most negative count maps to 2^(COUNT_W-1), which still fits.
  always_comb begin
    cmd_mag = cmd_steps;
    if (cmd_steps[COUNT_W-1]) begin
      cmd_mag = (~cmd_steps) + COUNT_W'(1);
    end
  end

  // WAIT spans wait_load + 1 cycles, which is (dly+1) * TICK_DIV.
  always_comb begin
    wait_load = (CNT_W'(dly) + CNT_W'(1)) * CNT_W'(TICK_DIV) - CNT_W'(1);
  end

  // Position after one step; it wraps modulo 2^POS_W.
  always_comb begin
    pos_next = dir_neg ? (position - inc) : (position + inc);
  end

  // Half-step phase table, indexed by the low three bits of the position.
  always_comb begin
    coil_next = 4'b1000;
    case (position[2:0])
      3'd0: coil_next = 4'b1000;
      3'd1: coil_next = 4'b1100;
      3'd2: coil_next = 4'b0100;
      3'd3: coil_next = 4'b0110;
      3'd4: coil_next = 4'b0010;
      3'd5: coil_next = 4'b0011;
      3'd6: coil_next = 4'b0001;
      3'd7: coil_next = 4'b1001;
      default: coil_next = 4'b1000;
    endcase
  end

  // Main controller. done, aborted and step_pulse are set on the edge that
  // enters DONE or STEP, so they line up with that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      position   <= '0;
      coil       <= 4'b1000;
      step_pulse <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      busy       <= 1'b0;
      cmd_ready  <= 1'b1;
      dir_neg    <= 1'b0;
      remaining  <= '0;
      inc        <= '0;
      dly        <= '0;
      dly_cnt    <= '0;
    end else begin
      // coil always follows the position with a one-cycle lag.
      coil       <= coil_next;
      step_pulse <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            dir_neg   <= cmd_steps[COUNT_W-1];
            remaining <= cmd_mag;
            inc       <= cmd_half ? POS_W'(1) : POS_W'(2);
            dly       <= cmd_delay;
            state     <= CHECK;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end else if (home) begin
            position <= '0;
          end
        end

        CHECK: begin
          if (abort) begin
            state   <= DONE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (remaining == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state      <= STEP;
            step_pulse <= 1'b1;
          end
        end

        // The step always completes. An abort here is seen again in WAIT.
        STEP: begin
          position  <= pos_next;
          remaining <= remaining - COUNT_W'(1);
          dly_cnt   <= wait_load;
          state     <= WAIT;
        end

        WAIT: begin
          if (abort) begin
            state   <= DONE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (dly_cnt == '0) begin
            state <= CHECK;
          end else begin
            dly_cnt <= dly_cnt - CNT_W'(1);
          end
        end

        DONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_move_scheduler.sv
module tb_stepper_move_scheduler;

  localparam int TD = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_steps = '0;
  logic       cmd_half = 1'b0;
  logic [7:0] cmd_delay = '0;
  logic       abort = 1'b0;
  logic       home = 1'b0;
  logic [7:0] position;
  logic [3:0] coil;
  logic       step_pulse;
  logic       busy;
  logic       done;
  logic       aborted;

  stepper_move_scheduler #(
    .POS_W(8),
    .COUNT_W(8),
    .DLY_W(8),
    .TICK_DIV(TD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps),
    .cmd_half(cmd_half),
    .cmd_delay(cmd_delay),
    .abort(abort),
    .home(home),
    .position(position),
    .coil(coil),
    .step_pulse(step_pulse),
    .busy(busy),
    .done(done),
    .aborted(aborted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] pos;
    logic       ab;
  } ev_t;

  ev_t sq[$];
  ev_t dq[$];

  int checks = 0;
  int passes = 0;
  int model_pos = 0;

  logic [3:0] coil_tab [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                               4'b0010, 4'b0011, 4'b0001, 4'b1001};

  function automatic logic [3:0] coil_of(input logic [7:0] p);
    return coil_tab[p[2:0]];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every step_pulse or done cycle is checked against the next queued event.
  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      if (step_pulse) begin
        if (sq.size() == 0) chk("unexpected_step", int'(step_pulse), 0);
        else begin
          e = sq.pop_front();
          chk("step_cycle", cyc, e.cyc);
          chk("step_pos", int'(position), int'(e.pos));
          chk("step_coil", int'(coil), int'(coil_of(e.pos)));
        end
      end
      if (done) begin
        if (dq.size() == 0) chk("unexpected_done", int'(done), 0);
        else begin
          e = dq.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("done_pos", int'(position), int'(e.pos));
          chk("done_aborted", int'(aborted), int'(e.ab));
          chk("done_coil", int'(coil), int'(coil_of(e.pos)));
          chk("done_busy", int'(busy), 1);
        end
      end
    end
  end

  // Inputs are driven at a negedge, so the active edge follows half a cycle later.
  // Offsets count from the acceptance cycle t: CHECK is at t+1, and step i
  // (starting from 0) pulses at t+2+i*P.
  task automatic issue(input int steps, input bit half, input int dly,
                       input int abort_off, input bit with_home);
    int P, n, n_ex, done_off, t, k, r, p, inc;
    bit ab;
    t = cyc;
    n = (steps < 0) ? -steps : steps;
    P = (dly + 1) * TD + 2;
    inc = half ? 1 : 2;
    n_ex = n;
    done_off = 2 + n * P;
    ab = 1'b0;
    if (abort_off >= 1 && abort_off <= 1 + n * P) begin
      k = (abort_off - 1) / P;
      r = (abort_off - 1) % P;
      if (r == 0) begin
        n_ex = k; ab = 1'b1; done_off = abort_off + 1;
      end else if (r >= 2) begin
        n_ex = k + 1; ab = 1'b1; done_off = abort_off + 1;
      end
    end
    p = model_pos;
    for (int i = 0; i < n_ex; i++) begin
      sq.push_back('{t + 2 + i * P, p[7:0], 1'b0});
      p = (p + ((steps < 0) ? 256 - inc : inc)) % 256;
    end
    dq.push_back('{t + done_off, p[7:0], ab});
    model_pos = p;

    cmd_valid = 1'b1;
    cmd_steps = steps[7:0];
    cmd_half  = half;
    cmd_delay = dly[7:0];
    home      = with_home;
    for (int o = 1; o <= done_off; o++) begin
      @(negedge clk);
      // Command inputs outside IDLE must be ignored, so drive noise on them.
      cmd_valid = 1'($urandom);
      cmd_steps = 8'($urandom);
      cmd_half  = 1'($urandom);
      cmd_delay = 8'($urandom);
      home      = 1'($urandom);
      abort     = (o == abort_off);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    home      = 1'b0;
    abort     = 1'b0;
    chk("back_to_idle", int'(cmd_ready), 1);
  endtask

  task automatic do_home();
    home = 1'b1;
    @(negedge clk);
    home = 1'b0;
    model_pos = 0;
    chk("home_pos", int'(position), 0);
    @(negedge clk);
    chk("home_coil", int'(coil), 4'b1000);
  endtask

  // Reset arrives in the first WAIT. With TD=2, WAIT lasts at least 2 cycles.
  task automatic reset_mid(input int steps, input bit half, input int dly);
    int t, inc;
    t = cyc;
    inc = half ? 1 : 2;
    sq.push_back('{t + 2, 8'(model_pos), 1'b0});
    cmd_valid = 1'b1;
    cmd_steps = steps[7:0];
    cmd_half  = half;
    cmd_delay = dly[7:0];
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    sq.delete();
    dq.delete();
    model_pos = 0;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_pos", int'(position), 0);
    chk("rst_mid_coil", int'(coil), 4'b1000);
    chk("rst_mid_ready", int'(cmd_ready), 1);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done", int'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int st, dl, ab_off, n, P;
    bit hf;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_pos", int'(position), 0);
    chk("rst_coil", int'(coil), 4'b1000);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_step", int'(step_pulse), 0);
    chk("rst_aborted", int'(aborted), 0);

    issue(3, 1'b1, 1, 0, 1'b0);
    do_home();
    issue(-2, 1'b0, 1, 0, 1'b0);
    issue(0, 1'b1, 2, 0, 1'b0);
    issue(5, 1'b1, 1, 10, 1'b0);
    issue(1, 1'b0, 0, 0, 1'b0);
    issue(4, 1'b1, 0, 5, 1'b0);
    issue(3, 1'b0, 0, 1, 1'b0);
    issue(-128, 1'b1, 0, 0, 1'b0);
    reset_mid(4, 1'b1, 1);
    do_home();
    issue(3, 1'b1, 0, 0, 1'b0);
    issue(2, 1'b0, 0, 0, 1'b1);
    do_home();

    for (int it = 0; it < 30; it++) begin
      st = int'($urandom_range(0, 14)) - 7;
      hf = 1'($urandom);
      dl = int'($urandom_range(0, 3));
      n  = (st < 0) ? -st : st;
      P  = (dl + 1) * TD + 2;
      ab_off = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3 + n * P)) : 0;
      issue(st, hf, dl, ab_off, 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 7) == 0) do_home();
    end

    @(negedge clk);
    chk("step_queue_empty", sq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
